// File: rtl/cic_interpolator.sv
// CIC interpolator: comb chain at the input rate, zero-stuffing upsampler, integrators at the tick rate.
// Define CIC_INTERP_SATURATE_EN to clamp the scaled output instead of letting it wrap.
module cic_interpolator #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STAGES        = 5,
  parameter int unsigned DDELAY        = 1,
  parameter int unsigned INTERPOLATION = 4096,
  parameter int unsigned WIDTHR        = 16
) (
  input  logic              clock,
  input  logic              clock_areset,
  input  logic [3:0]        gain,
  input  logic              sample_enable,
  input  logic              data_in_valid,
  input  logic [WIDTH-1:0]  data_in,
  output logic              data_in_ready,
  output logic              data_out_valid,
  output logic [WIDTHR-1:0] data_out,
  output logic              underrun
);

  localparam int unsigned WIDTHO =
      WIDTH + STAGES * $clog2(INTERPOLATION * DDELAY) - $clog2(INTERPOLATION);
  localparam int unsigned PhaseW   = $clog2(INTERPOLATION);
  localparam int          MaxShift = int'(WIDTHO) - int'(WIDTHR);

  logic [PhaseW-1:0]        phase_q, phase_d;
  logic                     hold_valid_q, hold_valid_d;
  logic signed [WIDTH-1:0]  hold_data_q, hold_data_d;
  logic signed [WIDTHO-1:0] sub_q [STAGES];
  logic signed [WIDTHO-1:0] sub_d [STAGES];
  logic signed [WIDTHO-1:0] dly_q [DDELAY][STAGES];
  logic signed [WIDTHO-1:0] dly_d [DDELAY][STAGES];
  logic signed [WIDTHO-1:0] acc_q [STAGES];
  logic signed [WIDTHO-1:0] acc_d [STAGES];
  logic [WIDTHR-1:0]        data_out_q, data_out_d;
  logic                     valid_q;
  logic                     underrun_q, underrun_d;

  logic                     phase0;
  logic                     xfer;
  logic signed [WIDTHO-1:0] comb_in;
  logic signed [WIDTHO-1:0] shifted;
  logic [WIDTHR-1:0]        scaled;
  int                       shift_amt;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign data_in_ready = ~hold_valid_q & ~clock_areset;
  assign xfer          = data_in_valid & data_in_ready;
  assign phase0        = sample_enable & (phase_q == '0);
  assign comb_in       = hold_valid_q ? WIDTHO'(hold_data_q) : '0;

  always_comb begin
    phase_d      = phase_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (sample_enable) begin
      phase_d = (phase_q == PhaseW'(INTERPOLATION - 1)) ? '0 : phase_q + 1'b1;
    end
    if (phase0) begin
      hold_valid_d = 1'b0;
    end
    // A transfer only happens with the register empty, so it never collides with a consume.
    if (xfer) begin
      hold_valid_d = 1'b1;
      hold_data_d  = $signed(data_in);
    end
    underrun_d = phase0 & ~hold_valid_q;
  end

  always_comb begin
    sub_d = sub_q;
    dly_d = dly_q;
    if (phase0) begin
      sub_d[0]    = comb_in - dly_q[DDELAY-1][0];
      dly_d[0][0] = comb_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        sub_d[i]    = sub_q[i-1] - dly_q[DDELAY-1][i];
        dly_d[0][i] = sub_q[i-1];
      end
      for (int k = 1; k < int'(DDELAY); k++) begin
        for (int i = 0; i < int'(STAGES); i++) begin
          dly_d[k][i] = dly_q[k-1][i];
        end
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (sample_enable) begin
      // Zero-stuffing: the comb result feeds the integrators only at phase 0.
      acc_d[0] = acc_q[0] + ((phase_q == '0) ? sub_q[STAGES-1] : '0);
      for (int i = 1; i < int'(STAGES); i++) begin
        acc_d[i] = acc_q[i] + acc_q[i-1];
      end
    end
  end

  always_comb begin
    shift_amt = MaxShift - int'(gain);
    if (shift_amt < 0) begin
      shift_amt = 0;
    end
    shifted = acc_q[STAGES-1] >>> shift_amt;
`ifdef CIC_INTERP_SATURATE_EN
    if (shifted > $signed({{(WIDTHO-WIDTHR+1){1'b0}}, {(WIDTHR-1){1'b1}}})) begin
      scaled = {1'b0, {(WIDTHR-1){1'b1}}};
    end else if (shifted < $signed({{(WIDTHO-WIDTHR+1){1'b1}}, {(WIDTHR-1){1'b0}}})) begin
      scaled = {1'b1, {(WIDTHR-1){1'b0}}};
    end else begin
      scaled = WIDTHR'(shifted);
    end
`else
    scaled = WIDTHR'(shifted);
`endif
    data_out_d = sample_enable ? scaled : data_out_q;
  end

  always_ff @(posedge clock or posedge clock_areset) begin
    if (clock_areset) begin
      phase_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      data_out_q   <= '0;
      valid_q      <= 1'b0;
      underrun_q   <= 1'b0;
      for (int i = 0; i < int'(STAGES); i++) begin
        sub_q[i] <= '0;
        acc_q[i] <= '0;
        for (int k = 0; k < int'(DDELAY); k++) begin
          dly_q[k][i] <= '0;
        end
      end
    end else begin
      phase_q      <= phase_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      data_out_q   <= data_out_d;
      valid_q      <= sample_enable;
      underrun_q   <= underrun_d;
      sub_q        <= sub_d;
      dly_q        <= dly_d;
      acc_q        <= acc_d;
    end
  end

  assign data_out_valid = valid_q;
  assign data_out       = data_out_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator (STAGES=3, INTERPOLATION=4, WIDTHR=16).
// Expected outputs come from a direct convolution of the consumed inputs with the CIC impulse shape.
module tb_cic_interpolator;

  localparam int Width  = 16;
  localparam int Stages = 3;
  localparam int Ddelay = 1;
  localparam int Interp = 4;
  localparam int WidthR = 16;
  localparam int WidthO = Width + Stages * $clog2(Interp * Ddelay) - $clog2(Interp);
  // Ticks from a phase-0 consume to the first output: comb pipeline, integrator pipeline, out reg.
  localparam int Lat    = Interp * Stages + Stages;
`ifdef CIC_INTERP_SATURATE_EN
  localparam int SatExp = 32767;
`else
  localparam int SatExp = -3072;
`endif

  logic              clock = 1'b0;
  logic              clock_areset = 1'b1;
  logic [3:0]        gain = 4'd4;
  logic              sample_enable = 1'b0;
  logic              data_in_valid = 1'b0;
  logic [Width-1:0]  data_in = '0;
  logic              data_in_ready;
  logic              data_out_valid;
  logic [WidthR-1:0] data_out;
  logic              underrun;

  cic_interpolator #(
    .WIDTH        (Width),
    .STAGES       (Stages),
    .DDELAY       (Ddelay),
    .INTERPOLATION(Interp),
    .WIDTHR       (WidthR)
  ) u_dut (
    .clock         (clock),
    .clock_areset  (clock_areset),
    .gain          (gain),
    .sample_enable (sample_enable),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .data_in_ready (data_in_ready),
    .data_out_valid(data_out_valid),
    .data_out      (data_out),
    .underrun      (underrun)
  );

  always #5 clock = ~clock;

  int   tests = 0;
  int   fails = 0;
  int   h_tab [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  int   v_hist[$];
  int   exp_q[$];
  int   src[$];
  int   nz[$];
  int   t_m, phase_m, hold_val_m, ur_seen, last_out;
  logic held_m;
  logic rec;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_out(input int t);
    longint                   sum;
    logic signed [WidthO-1:0] w;
    logic signed [WidthO-1:0] s;
    logic signed [WidthR-1:0] tr;
    int                       j;
    int                       sh;
    sum = 0;
    foreach (v_hist[p]) begin
      j = t - Lat - Interp * p;
      if (j >= 0 && j < 10) sum += longint'(v_hist[p]) * longint'(h_tab[j]);
    end
    w  = sum[WidthO-1:0];
    sh = WidthO - WidthR - int'(gain);
    if (sh < 0) sh = 0;
    s = w >>> sh;
`ifdef CIC_INTERP_SATURATE_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
`else
    tr = s[WidthR-1:0];
    return int'(tr);
`endif
  endfunction

  task automatic model_reset();
    t_m        = 0;
    phase_m    = 0;
    held_m     = 1'b0;
    hold_val_m = 0;
    v_hist.delete();
    exp_q.delete();
    src.delete();
  endtask

  // One clock: drive inputs, advance the model, then check outputs #1 after the edge.
  task automatic step(input logic se, input logic idle);
    logic vld;
    logic xfer;
    logic exp_ur;
    int   din;
    vld = !idle && (src.size() > 0);
    din = vld ? src[0] : 0;
    sample_enable = se;
    data_in_valid = vld;
    data_in       = Width'(din);
    chk("ready", int'(data_in_ready), int'(!held_m));
    xfer   = vld && !held_m;
    exp_ur = 1'b0;
    if (se && phase_m == 0) begin
      if (held_m) begin
        v_hist.push_back(hold_val_m);
        held_m = 1'b0;
      end else begin
        v_hist.push_back(0);
        exp_ur = 1'b1;
      end
    end
    if (xfer) begin
      held_m     = 1'b1;
      hold_val_m = din;
      void'(src.pop_front());
    end
    if (se) begin
      exp_q.push_back(model_out(t_m));
      t_m++;
      phase_m = (phase_m == Interp - 1) ? 0 : phase_m + 1;
    end
    @(posedge clock);
    #1;
    chk("out_valid", int'(data_out_valid), int'(se));
    chk("underrun", int'(underrun), int'(exp_ur));
    if (underrun) ur_seen++;
    if (data_out_valid) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) chk("data_out", int'($signed(data_out)), exp_q.pop_front());
      last_out = int'($signed(data_out));
      if (rec && data_out != '0) nz.push_back(last_out);
    end
  endtask

  task automatic load_impulse();
    src.delete();
    src.push_back(1);
    repeat (15) src.push_back(0);
    nz.delete();
    rec = 1'b1;
  endtask

  task automatic check_impulse(input string tag);
    rec = 1'b0;
    chk({tag, "_len"}, nz.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < nz.size()) chk({tag, "_val"}, nz[i], h_tab[i]);
    end
  endtask

  initial begin
    int n;
    rec      = 1'b0;
    ur_seen  = 0;
    last_out = 0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_ready", int'(data_in_ready), 0);
    chk("rst_valid", int'(data_out_valid), 0);
    chk("rst_underrun", int'(underrun), 0);
    clock_areset = 1'b0;
    #1;
    chk("release_ready", int'(data_in_ready), 1);

    // Impulse, continuous ticks
    load_impulse();
    step(1'b0, 1'b0);
    repeat (Interp * 12) step(1'b1, 1'b0);
    check_impulse("impulse");

    // DC level, upstream always valid
    src.delete();
    repeat (30) src.push_back(1000);
    step(1'b0, 1'b0);
    ur_seen = 0;
    repeat (Interp * 20) step(1'b1, 1'b0);
    chk("dc_level", last_out, 16000);
    chk("dc_no_underrun", ur_seen, 0);
    gain = 4'd0;
    repeat (8) step(1'b1, 1'b0);
    chk("dc_gain0", last_out, 1000);
    gain = 4'd4;

    // Underrun: withhold valid across one phase-0 tick, then offer a distinct sample
    src.delete();
    src.push_back(2000);
    repeat (20) src.push_back(1000);
    n = 0;
    while (!(phase_m == 1 && !held_m) && n < 16) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("ur_align", phase_m, 1);
    ur_seen = 0;
    repeat (Interp) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    repeat (Interp * 8) step(1'b1, 1'b0);
    chk("ur_count", ur_seen, 1);

    // Saturation / wrap at steady state 128000
    src.delete();
    repeat (20) src.push_back(8000);
    repeat (Interp * 14) step(1'b1, 1'b0);
    chk("sat_level", last_out, SatExp);

    // Reset mid-period with a sample held
    n = 0;
    while (!(held_m && phase_m != 0) && n < 16) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("held_before_rst", int'(held_m), 1);
    clock_areset = 1'b1;
    #1;
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_ready", int'(data_in_ready), 0);
    chk("midrst_valid", int'(data_out_valid), 0);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("midrst_hold_out", int'(data_out), 0);
      chk("midrst_hold_valid", int'(data_out_valid), 0);
      chk("midrst_hold_ur", int'(underrun), 0);
    end
    sample_enable = 1'b0;
    data_in_valid = 1'b0;
    clock_areset  = 1'b0;
    model_reset();
    #1;
    chk("midrst_release_ready", int'(data_in_ready), 1);
    load_impulse();
    step(1'b0, 1'b0);
    repeat (Interp * 12) step(1'b1, 1'b0);
    check_impulse("impulse_after_rst");

    // Sparse ticks: sample_enable every third cycle
    load_impulse();
    step(1'b0, 1'b0);
    for (int c = 0; c < 3 * Interp * 12; c++) step((c % 3) == 0, 1'b0);
    check_impulse("impulse_sparse");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
